// File: rtl/pb_pkg.sv
// pb_pkg: shared types and constants for the packet builder.
//   pb_state_t  - builder FSM states
//   PKT_SOP     - 3-bit start-of-packet marker in header byte1
//   CRC8_POLY   - CRC8 polynomial (x^8 + x^2 + x + 1)
//   HDR_LEN     - header length in bytes (payload starts at hdr + HDR_LEN)
//   CRC_OFS     - CRC byte sits at hdr + cnt + CRC_OFS
//   ecc_hamming - returns {parity_of_all_bits, ecc[3:0]} for the 8-bit header word
package pb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrLo,
    StHdrHi,
    StData,
    StCrcWr,
    StDone
  } pb_state_t;

  localparam logic [2:0]  PKT_SOP   = 3'b101;
  localparam logic [7:0]  CRC8_POLY = 8'h07;
  localparam int unsigned HDR_LEN   = 2;
  localparam int unsigned CRC_OFS   = 3;

  function automatic logic [4:0] ecc_hamming(input logic [7:0] d);
    logic [4:0] e;
    e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    e[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
    e[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
    e[4] = ^d;
    return e;
  endfunction

endpackage

// File: rtl/pb_pkt_builder_if.sv
// pb_pkt_builder_if: memory-side bus of the packet builder.
//   src_addr     - source memory read address (data returns one cycle later)
//   src_data_o   - source memory read data, byte in [7:0]
//   inmem_addr   - inmem byte write address
//   inmem_we     - inmem byte write strobe
//   inmem_data_i - inmem write data, byte in [7:0]
// Modports: master = builder side, slave = memory side.
interface pb_pkt_builder_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_data_o;
  logic [ADDR_W-1:0] inmem_addr;
  logic              inmem_we;
  logic [DATA_W-1:0] inmem_data_i;

  modport master (
    output src_addr,
    input  src_data_o,
    output inmem_addr,
    output inmem_we,
    output inmem_data_i
  );

  modport slave (
    input  src_addr,
    output src_data_o,
    input  inmem_addr,
    input  inmem_we,
    input  inmem_data_i
  );
endinterface

// File: rtl/crc8_byte_calc.sv
// crc8_byte_calc: one-byte CRC8 update, MSB first, no reflection.
//   crc_in   - running CRC
//   data_in  - next byte
//   crc_out  - CRC after absorbing data_in
module crc8_byte_calc
  import pb_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/pb_pkt_builder.sv
// pb_pkt_builder: copies pb_byte_cnt+1 payload bytes from source memory into inmem,
// framed by a 2-byte header {cnt,ecc},{SOP,ecc_msb,type} and a trailing CRC8 byte.
//   clk, reset (async, active low)
//   pb_start, pb_addr_src, pb_addr_hdr, pb_byte_cnt, pb_pkt_type - request, sampled in idle
//   pb_busy - high while not idle; pb_irq - one-cycle done pulse
//   mem     - source read / inmem write bus (pb_pkt_builder_if.master)
// Optional: PB_ECC_ERR_INJ_EN adds pb_ecc_inj[1:0] to corrupt header byte0 for testing.
module pb_pkt_builder
  import pb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pb_start,
  input  logic [ADDR_W-1:0] pb_addr_src,
  input  logic [ADDR_W-1:0] pb_addr_hdr,
  input  logic [3:0]        pb_byte_cnt,
  input  logic [3:0]        pb_pkt_type,
`ifdef PB_ECC_ERR_INJ_EN
  input  logic [1:0]        pb_ecc_inj,
`endif
  output logic              pb_busy,
  output logic              pb_irq,
  pb_pkt_builder_if.master  mem
);

  pb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] src_q, hdr_q;
  logic [3:0]        cnt_q, type_q;
  logic [3:0]        k_q, k_d;
  logic [7:0]        crc_q, crc_d, crc_next;
  logic              accept;
  logic [4:0]        ecc;
  logic [7:0]        hdr0, src_byte;
  logic              unused_src_hi;

`ifdef PB_ECC_ERR_INJ_EN
  logic [1:0]        inj_q;
`endif

  assign accept        = (state_q == StIdle) && pb_start;
  assign src_byte      = mem.src_data_o[7:0];
  assign unused_src_hi = ^mem.src_data_o[DATA_W-1:8];
  assign ecc           = ecc_hamming({type_q, cnt_q});

  // Corruption is applied after ECC so the receiver sees a mismatching header.
  always_comb begin
    hdr0 = {cnt_q, ecc[3:0]};
`ifdef PB_ECC_ERR_INJ_EN
    if (inj_q == 2'b01) hdr0 = hdr0 ^ 8'h10;
    if (inj_q == 2'b10) hdr0 = hdr0 ^ 8'h30;
`endif
  end

  crc8_byte_calc u_crc (
    .crc_in  (crc_q),
    .data_in (src_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      hdr_q   <= '0;
      cnt_q   <= '0;
      type_q  <= '0;
      k_q     <= '0;
      crc_q   <= '0;
`ifdef PB_ECC_ERR_INJ_EN
      inj_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      crc_q   <= crc_d;
      if (accept) begin
        src_q  <= pb_addr_src;
        hdr_q  <= pb_addr_hdr;
        cnt_q  <= pb_byte_cnt;
        type_q <= pb_pkt_type;
`ifdef PB_ECC_ERR_INJ_EN
        inj_q  <= pb_ecc_inj;
`endif
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    crc_d            = crc_q;
    pb_busy          = (state_q != StIdle);
    pb_irq           = 1'b0;
    mem.src_addr     = '0;
    mem.inmem_we     = 1'b0;
    mem.inmem_addr   = '0;
    mem.inmem_data_i = '0;

    case (state_q)
      StIdle: begin
        if (pb_start) begin
          crc_d   = '0;
          k_d     = '0;
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        mem.inmem_we     = 1'b1;
        mem.inmem_addr   = hdr_q;
        mem.inmem_data_i = DATA_W'(hdr0);
        state_d          = StHdrHi;
      end
      StHdrHi: begin
        mem.inmem_we     = 1'b1;
        mem.inmem_addr   = hdr_q + ADDR_W'(1);
        mem.inmem_data_i = DATA_W'({PKT_SOP, ecc[4], type_q});
        mem.src_addr     = src_q;
        k_d              = '0;
        state_d          = StData;
      end
      StData: begin
        // Byte k arrives now from the read issued in the previous cycle.
        mem.inmem_we     = 1'b1;
        mem.inmem_addr   = hdr_q + ADDR_W'(HDR_LEN) + ADDR_W'(k_q);
        mem.inmem_data_i = DATA_W'(src_byte);
        crc_d            = crc_next;
        if (k_q != cnt_q) begin
          mem.src_addr = src_q + ADDR_W'(k_q) + ADDR_W'(1);
          k_d          = k_q + 4'd1;
        end else begin
          state_d = StCrcWr;
        end
      end
      StCrcWr: begin
        mem.inmem_we     = 1'b1;
        mem.inmem_addr   = hdr_q + ADDR_W'(cnt_q) + ADDR_W'(CRC_OFS);
        mem.inmem_data_i = DATA_W'(crc_q);
        state_d          = StDone;
      end
      StDone: begin
        pb_irq  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_pb_pkt_builder.sv
// tb_pb_pkt_builder: directed tests for pb_pkt_builder. A packet model builds the
// expected per-cycle output trace; a negedge monitor compares the DUT every cycle.
module tb_pb_pkt_builder;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          busy;
    logic          irq;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] src;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          pb_start;
  logic [AW-1:0] pb_addr_src;
  logic [AW-1:0] pb_addr_hdr;
  logic [3:0]    pb_byte_cnt;
  logic [3:0]    pb_pkt_type;
  logic          pb_busy;
  logic          pb_irq;
`ifdef PB_ECC_ERR_INJ_EN
  logic [1:0]    pb_ecc_inj;
`endif

  logic [7:0] src_mem [0:(1<<AW)-1];
  logic [7:0] inmem   [0:(1<<AW)-1];

  int   n_cmp;
  int   n_fail;
  int   irq_cnt;
  exp_t exp_q[$];
  logic [7:0] model_crc;

  pb_pkt_builder_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  pb_pkt_builder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pb_start    (pb_start),
    .pb_addr_src (pb_addr_src),
    .pb_addr_hdr (pb_addr_hdr),
    .pb_byte_cnt (pb_byte_cnt),
    .pb_pkt_type (pb_pkt_type),
`ifdef PB_ECC_ERR_INJ_EN
    .pb_ecc_inj  (pb_ecc_inj),
`endif
    .pb_busy     (pb_busy),
    .pb_irq      (pb_irq),
    .mem         (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: registered read, one cycle latency.
  always @(posedge clk) mem_if.src_data_o <= {24'h0, src_mem[mem_if.src_addr]};
  always @(posedge clk) if (mem_if.inmem_we) inmem[mem_if.inmem_addr] <= mem_if.inmem_data_i[7:0];

  // ---------------- model ----------------
  function automatic logic [7:0] m_crc_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ b[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] m_hdr0(input logic [3:0] ty, input logic [3:0] cn,
                                        input logic [1:0] inj);
    logic [7:0] d;
    logic [7:0] h;
    d = {ty, cn};
    h = {cn, d[4]^d[5]^d[6]^d[7], d[1]^d[2]^d[3]^d[7],
         d[0]^d[2]^d[3]^d[5]^d[6], d[0]^d[1]^d[3]^d[4]^d[6]};
`ifdef PB_ECC_ERR_INJ_EN
    if (inj == 2'b01) h[4] = ~h[4];
    if (inj == 2'b10) h[5:4] = ~h[5:4];
`else
    if (inj != 2'b00) h = h;
`endif
    return h;
  endfunction

  function automatic logic [7:0] m_hdr1(input logic [3:0] ty, input logic [3:0] cn);
    logic [7:0] d;
    d = {ty, cn};
    return {3'b101, ^d, ty};
  endfunction

  task automatic build_trace(input logic [3:0] ty, input logic [3:0] cn,
                             input logic [AW-1:0] sa, input logic [AW-1:0] ha,
                             input logic [1:0] inj);
    exp_t       e;
    logic [7:0] crc;
    logic [7:0] b;
    crc    = 8'h00;
    e      = '0;
    e.busy = 1'b1;
    e.we   = 1'b1;
    e.addr = ha;
    e.data = {24'h0, m_hdr0(ty, cn, inj)};
    exp_q.push_back(e);
    e.addr = ha + 14'd1;
    e.data = {24'h0, m_hdr1(ty, cn)};
    e.src  = sa;
    exp_q.push_back(e);
    for (int k = 0; k <= int'(cn); k++) begin
      b      = src_mem[sa + AW'(k)];
      e.addr = ha + AW'(k + 2);
      e.data = {24'h0, b};
      e.src  = (k < int'(cn)) ? sa + AW'(k + 1) : '0;
      crc    = m_crc_step(crc, b);
      exp_q.push_back(e);
    end
    e.addr = ha + AW'(int'(cn) + 3);
    e.data = {24'h0, crc};
    e.src  = '0;
    exp_q.push_back(e);
    e      = '0;
    e.busy = 1'b1;
    e.irq  = 1'b1;
    exp_q.push_back(e);
    model_crc = crc;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    a = {pb_busy, pb_irq, mem_if.inmem_we, mem_if.inmem_addr, mem_if.inmem_data_i,
         mem_if.src_addr};
    if (!reset) begin
      exp_q.delete();
      e = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = '0;
    end
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL out_vec t=%0t got busy=%b irq=%b we=%b addr=%h data=%h src=%h want busy=%b irq=%b we=%b addr=%h data=%h src=%h",
               $time, a.busy, a.irq, a.we, a.addr, a.data, a.src,
               e.busy, e.irq, e.we, e.addr, e.data, e.src);
    end
    if (pb_irq) irq_cnt++;
  end

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic run_pkt(input logic [3:0] ty, input logic [3:0] cn, input logic [AW-1:0] sa,
                         input logic [AW-1:0] ha, input logic [1:0] inj, input bit repulse,
                         input int want_irq_cyc);
    int got;
    int irq0;
    got  = -1;
    irq0 = irq_cnt;
    @(negedge clk);
    pb_start    = 1'b1;
    pb_pkt_type = ty;
    pb_byte_cnt = cn;
    pb_addr_src = sa;
    pb_addr_hdr = ha;
`ifdef PB_ECC_ERR_INJ_EN
    pb_ecc_inj  = inj;
`endif
    @(posedge clk);
    build_trace(ty, cn, sa, ha, inj);
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      pb_start = repulse && (j == 3 || j == int'(cn) + 5);
      if (repulse) begin
        pb_pkt_type = ~ty;
        pb_byte_cnt = ~cn;
        pb_addr_hdr = ha ^ 14'h155;
      end
      if (pb_irq) begin
        got = j;
        break;
      end
    end
    @(negedge clk);
    pb_start = 1'b0;
    repeat (2) @(negedge clk);
    check_int("irq_cycle", got, want_irq_cyc);
    check_int("irq_count", irq_cnt - irq0, 1);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    irq_cnt  = 0;
    reset    = 1'b0;
    pb_start = 1'b0;
    pb_addr_src = '0;
    pb_addr_hdr = '0;
    pb_byte_cnt = '0;
    pb_pkt_type = '0;
`ifdef PB_ECC_ERR_INJ_EN
    pb_ecc_inj  = 2'b00;
`endif
    for (int i = 0; i < (1 << AW); i++) begin
      src_mem[i] = 8'(i * 7 + 3);
      inmem[i]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Minimal packet.
    src_mem[14'h100] = 8'h00;
    run_pkt(4'd0, 4'd0, 14'h100, 14'h000, 2'b00, 1'b0, 5);
    check_int("t1_hdr0", inmem[0], 8'h00);
    check_int("t1_hdr1", inmem[1], 8'hA0);
    check_int("t1_pay",  inmem[2], 8'h00);
    check_int("t1_crc",  inmem[3], 8'h00);

    // type 3, three bytes.
    src_mem[14'h200] = 8'h01;
    src_mem[14'h201] = 8'h00;
    src_mem[14'h202] = 8'h00;
    run_pkt(4'd3, 4'd2, 14'h200, 14'h040, 2'b00, 1'b0, 7);
    check_int("t2_hdr0", inmem[14'h040], 8'h26);
    check_int("t2_hdr1", inmem[14'h041], 8'hB3);
    check_int("t2_crc",  inmem[14'h045], 8'h6B);

    // CRC check value over "123456789".
    for (int i = 0; i < 9; i++) src_mem[14'h300 + AW'(i)] = 8'(8'h31 + i);
    run_pkt(4'd5, 4'd8, 14'h300, 14'h100, 2'b00, 1'b0, 13);
    check_int("t3_crc", inmem[14'h10B], 8'hF4);

    // Header and source address wrap.
    src_mem[14'h3FFF] = 8'hAB;
    src_mem[14'h0000] = 8'h00;
    run_pkt(4'd1, 4'd1, 14'h3FFF, 14'h3FFE, 2'b00, 1'b0, 6);
    check_int("t4_hdr0", inmem[14'h3FFE], 8'h1A);
    check_int("t4_hdr1", inmem[14'h3FFF], 8'hA1);
    check_int("t4_pay0", inmem[14'h0000], 8'hAB);
    check_int("t4_pay1", inmem[14'h0001], 8'h00);
    check_int("t4_crc",  inmem[14'h0002], int'(model_crc));

    // Start re-pulsed in DATA and DONE; followed immediately by a new packet.
    run_pkt(4'd2, 4'd3, 14'h400, 14'h200, 2'b00, 1'b1, 8);
    run_pkt(4'd7, 4'd4, 14'h410, 14'h220, 2'b00, 1'b0, 9);

    // Reset in cycle 3 aborts the packet.
    begin
      int irq0;
      irq0 = irq_cnt;
      @(negedge clk);
      pb_start    = 1'b1;
      pb_pkt_type = 4'd4;
      pb_byte_cnt = 4'd5;
      pb_addr_src = 14'h500;
      pb_addr_hdr = 14'h300;
      @(posedge clk);
      build_trace(4'd4, 4'd5, 14'h500, 14'h300, 2'b00);
      @(negedge clk);
      pb_start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      exp_q.delete();
      #1;
      check_int("rst_outs", int'({pb_busy, pb_irq, mem_if.inmem_we}), 0);
      check_int("rst_addr", int'(mem_if.inmem_addr) + int'(mem_if.src_addr), 0);
      check_int("rst_data", int'(mem_if.inmem_data_i), 0);
      repeat (12) @(negedge clk);
      check_int("rst_irq", irq_cnt - irq0, 0);
      check_int("rst_h0", inmem[14'h300], 8'h5E);
      check_int("rst_h1", inmem[14'h301], 8'hB4);
      check_int("rst_nopay", inmem[14'h302], 8'h00);
      @(posedge clk);
      #3 reset = 1'b1;
      repeat (2) @(negedge clk);
    end

    // Packet after reset recovery.
    run_pkt(4'd9, 4'd2, 14'h200, 14'h500, 2'b00, 1'b0, 7);

`ifdef PB_ECC_ERR_INJ_EN
    run_pkt(4'd3, 4'd2, 14'h200, 14'h600, 2'b01, 1'b0, 7);
    check_int("inj_hdr0", inmem[14'h600], 8'h36);
    check_int("inj_hdr1", inmem[14'h601], 8'hB3);
    check_int("inj_crc",  inmem[14'h605], 8'h6B);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
